// File: rtl/n_bit_down_counter_if.sv
// Bundle of the down counter's control and status signals.
// Ports: load/load_val/en/auto_reload in; count_out/done/busy out.
interface n_bit_down_counter_if #(
   parameter int N = 3
);
   logic         load;
   logic [N-1:0] load_val;
   logic         en;
   logic         auto_reload;
   logic [N-1:0] count_out;
   logic         done;
   logic         busy;

   modport master (
      output load,
      output load_val,
      output en,
      output auto_reload,
      input  count_out,
      input  done,
      input  busy
   );

   modport slave (
      input  load,
      input  load_val,
      input  en,
      input  auto_reload,
      output count_out,
      output done,
      output busy
   );
endinterface

// File: rtl/n_bit_down_counter.sv
// Loadable N-bit down counter, one-cycle done pulse, optional reload.
// Ports: clk, rst (sync high), bus (slave: load, load_val, en,
//        auto_reload in; count_out, done, busy out, all registered).
module n_bit_down_counter #(
   parameter int N = 3
) (
   input logic                   clk,
   input logic                   rst,
   n_bit_down_counter_if.slave   bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t       state_q, state_d;
   logic [N-1:0] count_q, count_d;
   logic [N-1:0] reload_q, reload_d;
   logic         done_q, done_d;

   localparam logic [N-1:0] ONE  = N'(1);
   localparam logic [N-1:0] ZERO = '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (bus.load) begin
         // a zero load clears instead of starting a count
         count_d  = bus.load_val;
         reload_d = bus.load_val;
         state_d  = (bus.load_val != ZERO) ? RUN : IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
            end
            RUN: begin
               if (bus.en) begin
                  if (count_q == ONE) begin
                     done_d = 1'b1;
                     if (bus.auto_reload) begin
                        count_d = reload_q;
                     end else begin
                        count_d = '0;
                        state_d = IDLE;
                     end
                  end else begin
                     count_d = count_q - ONE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign bus.count_out = count_q;
   assign bus.done      = done_q;
   assign bus.busy      = (state_q == RUN);

endmodule

// File: tb/tb_n_bit_down_counter.sv
// Directed self-checking bench for n_bit_down_counter, N=3.
// Drives the interface master side; checks after each rising edge.
module tb_n_bit_down_counter;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   n_bit_down_counter_if #(.N(3)) bus ();

   n_bit_down_counter #(.N(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk3(input string tag, input int c,
                       input int d, input int b);
      chk({tag, ".count"}, int'(bus.count_out), c);
      chk({tag, ".done"}, int'(bus.done), d);
      chk({tag, ".busy"}, int'(bus.busy), b);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      bus.load = 1'b1;
      bus.load_val = 3'd5;
      bus.en = 1'b0;
      bus.auto_reload = 1'b0;
      step();
      step();
      chk3("reset", 0, 0, 0);

      // basic count from 5
      rst = 1'b0;
      bus.en = 1'b1;
      step();
      chk3("basic_load", 5, 0, 1);
      bus.load = 1'b0;
      for (int i = 4; i >= 1; i--) begin
         step();
         chk3("basic_dec", i, 0, 1);
      end
      step();
      chk3("basic_term", 0, 1, 0);
      step();
      chk3("basic_hold", 0, 0, 0);

      // enable gaps
      bus.load = 1'b1;
      bus.load_val = 3'd3;
      step();
      chk3("gap_load", 3, 0, 1);
      bus.load = 1'b0;
      bus.en = 1'b1; step(); chk3("gap1", 2, 0, 1);
      bus.en = 1'b0; step(); chk3("gap2", 2, 0, 1);
      bus.en = 1'b0; step(); chk3("gap3", 2, 0, 1);
      bus.en = 1'b1; step(); chk3("gap4", 1, 0, 1);
      bus.en = 1'b1; step(); chk3("gap5", 0, 1, 0);

      // auto-reload period 2
      bus.load = 1'b1;
      bus.load_val = 3'd2;
      bus.auto_reload = 1'b1;
      step();
      chk3("ar_load", 2, 0, 1);
      bus.load = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk3("ar_cyc", (k % 2 == 1) ? 1 : 2,
              (k % 2 == 0) ? 1 : 0, 1);
      end

      // auto-reload period 1
      bus.load = 1'b1;
      bus.load_val = 3'd1;
      step();
      chk3("ar1_load", 1, 0, 1);
      bus.load = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk3("ar1_cyc", 1, 1, 1);
      end
      bus.auto_reload = 1'b0;
      step();
      chk3("ar1_stop", 0, 1, 0);

      // zero load is a clear
      bus.load = 1'b1;
      bus.load_val = 3'd0;
      step();
      chk3("zero_load", 0, 0, 0);
      bus.load = 1'b0;
      bus.auto_reload = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk3("zero_idle", 0, 0, 0);
      end
      bus.auto_reload = 1'b0;

      // max load 7
      bus.load = 1'b1;
      bus.load_val = 3'd7;
      step();
      chk3("max_load", 7, 0, 1);
      bus.load = 1'b0;
      for (int i = 6; i >= 1; i--) begin
         step();
         chk3("max_dec", i, 0, 1);
      end
      step();
      chk3("max_term", 0, 1, 0);

      // reload mid-count at 2
      bus.load = 1'b1;
      bus.load_val = 3'd6;
      step();
      bus.load = 1'b0;
      for (int i = 5; i >= 2; i--) begin
         step();
         chk3("mid_dec", i, 0, 1);
      end
      bus.load = 1'b1;
      step();
      chk3("mid_reload", 6, 0, 1);
      bus.load = 1'b0;
      for (int i = 5; i >= 1; i--) begin
         step();
         chk3("mid_dec2", i, 0, 1);
      end
      step();
      chk3("mid_term", 0, 1, 0);

      // reset mid-count beats load and en
      bus.load = 1'b1;
      bus.load_val = 3'd6;
      step();
      bus.load = 1'b0;
      step();
      step();
      chk3("rst_pre", 4, 0, 1);
      rst = 1'b1;
      bus.load = 1'b1;
      bus.load_val = 3'd3;
      step();
      chk3("rst_mid", 0, 0, 0);
      rst = 1'b0;
      bus.load_val = 3'd4;
      step();
      chk3("post_load", 4, 0, 1);
      bus.load = 1'b0;
      for (int i = 3; i >= 1; i--) begin
         step();
         chk3("post_dec", i, 0, 1);
      end

      // load on the terminal edge wins
      bus.load = 1'b1;
      bus.load_val = 3'd2;
      step();
      chk3("term_load", 2, 0, 1);
      bus.load = 1'b0;
      step();
      chk3("term_dec", 1, 0, 1);
      step();
      chk3("term_end", 0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
